// File: rtl/mem_req_arbiter.sv
// Arbitrates NCH CPU-side request channels onto a single toggle-handshake SDRAM port.
// Round-robin grant, one outstanding transfer, with a saturating timeout abort.
module mem_req_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int TMO = 255
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_cs,
  input  logic [NCH-1:0]    ch_oe,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_ad,
  input  logic [NCH*DW-1:0] ch_d,
  output logic [NCH*DW-1:0] ch_q,
  output logic [NCH-1:0]    ch_busy,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [AW-1:0]     mem_a,
  output logic [1:0]        mem_ds,
  output logic              mem_we,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q,
  output logic              err,
  output logic [1:0]        err_ch
);

  // state | meaning
  // IDLE  | no transfer outstanding; grant the next pending channel
  // WAIT  | transfer issued; wait for mem_ack == mem_req or timeout
  typedef enum logic {IDLE, WAIT} state_t;

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(TMO + 1);

  state_t          state;
  logic [GW-1:0]   grant, last_grant;
  logic [CW-1:0]   tmo_cnt;

  logic [NCH-1:0]  rd_prev, wr_prev, pending, shadow_pend;
  logic [AW-1:0]   ad_prev [NCH];
  logic [AW-1:0]   slot_ad [NCH];
  logic [NCH-1:0]  slot_we;
  logic [DW-1:0]   slot_d  [NCH];
  logic [AW-1:0]   shadow_ad [NCH];
  logic [NCH-1:0]  shadow_we;
  logic [DW-1:0]   shadow_d  [NCH];

  logic [NCH-1:0]  rd_now, wr_now, trig, svc;
  logic            done;
  logic            pick_ok;
  logic [GW-1:0]   pick;
  logic [AW-1:0]   pick_ad;
  logic            pick_we;
  logic [DW-1:0]   pick_d;
  logic [1:0]      ds_next;
  logic [15:0]     d_next;
  logic [DW-1:0]   q_sel;

  assign rd_now  = ch_cs & ch_oe;
  assign wr_now  = ch_cs & ch_we;
  assign done    = (state == WAIT) && ((mem_ack == mem_req) || (tmo_cnt == '0));
  assign ch_busy = pending | svc;

  always_comb begin
    trig = '0;
    svc  = '0;
    for (int i = 0; i < NCH; i++) begin
      trig[i] = (rd_now[i] & ~rd_prev[i]) | (wr_now[i] & ~wr_prev[i]) |
                (rd_now[i] & (ch_ad[i*AW +: AW] != ad_prev[i]));
      svc[i]  = (state == WAIT) && (grant == GW'(i));
    end
  end

  // round-robin search starting just after the last completed grant
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int j = 1; j <= NCH; j++) begin
      idx = (int'(last_grant) + j) % NCH;
      if (!pick_ok && pending[idx]) begin
        pick    = GW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    pick_ad = slot_ad[pick];
    pick_we = slot_we[pick];
    pick_d  = slot_d[pick];
    ds_next = (DW == 8 && pick_we) ? (pick_ad[0] ? 2'b10 : 2'b01) : 2'b11;
    d_next  = (DW == 8) ? {2{pick_d[7:0]}} : 16'(pick_d);
    if (DW == 8) q_sel = DW'(mem_a[0] ? mem_q[15:8] : mem_q[7:0]);
    else         q_sel = DW'(mem_q);
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GW'(NCH - 1);
      tmo_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_a       <= '0;
      mem_ds      <= '0;
      mem_we      <= 1'b0;
      mem_d       <= '0;
      ch_q        <= '0;
      err         <= 1'b0;
      err_ch      <= '0;
      rd_prev     <= '0;
      wr_prev     <= '0;
      pending     <= '0;
      shadow_pend <= '0;
      slot_we     <= '0;
      shadow_we   <= '0;
      for (int i = 0; i < NCH; i++) begin
        ad_prev[i]   <= '0;
        slot_ad[i]   <= '0;
        slot_d[i]    <= '0;
        shadow_ad[i] <= '0;
        shadow_d[i]  <= '0;
      end
    end else begin
      err     <= 1'b0;
      rd_prev <= rd_now;
      wr_prev <= wr_now;
      for (int i = 0; i < NCH; i++) begin
        ad_prev[i] <= ch_ad[i*AW +: AW];
        // the slot in service is frozen; a new trigger parks in the shadow until completion
        if (trig[i]) begin
          if (svc[i] && !done) begin
            shadow_ad[i]   <= ch_ad[i*AW +: AW];
            shadow_we[i]   <= wr_now[i];
            shadow_d[i]    <= ch_d[i*DW +: DW];
            shadow_pend[i] <= 1'b1;
          end else begin
            slot_ad[i]     <= ch_ad[i*AW +: AW];
            slot_we[i]     <= wr_now[i];
            slot_d[i]      <= ch_d[i*DW +: DW];
            pending[i]     <= 1'b1;
            shadow_pend[i] <= 1'b0;
          end
        end else if (svc[i] && done) begin
          if (shadow_pend[i]) begin
            slot_ad[i]     <= shadow_ad[i];
            slot_we[i]     <= shadow_we[i];
            slot_d[i]      <= shadow_d[i];
            shadow_pend[i] <= 1'b0;
          end else begin
            pending[i]     <= 1'b0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant   <= pick;
            mem_a   <= pick_ad;
            mem_we  <= pick_we;
            mem_ds  <= ds_next;
            mem_d   <= d_next;
            mem_req <= ~mem_req;
            tmo_cnt <= CW'(TMO - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack == mem_req) begin
            if (!mem_we) ch_q[int'(grant)*DW +: DW] <= q_sel;
            last_grant <= grant;
            state      <= IDLE;
          end else if (tmo_cnt == '0) begin
            err    <= 1'b1;
            err_ch <= 2'(grant);
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected SDRAM requests are queued by the
// stimulus and checked by a monitor whenever mem_req toggles.
module tb_mem_req_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TMO = 8;

  logic              clk_24;
  logic              reset;
  logic [NCH-1:0]    ch_cs, ch_oe, ch_we;
  logic [NCH*AW-1:0] ch_ad;
  logic [NCH*DW-1:0] ch_d;
  logic [NCH*DW-1:0] ch_q;
  logic [NCH-1:0]    ch_busy;
  logic              mem_req, mem_ack;
  logic [AW-1:0]     mem_a;
  logic [1:0]        mem_ds;
  logic              mem_we;
  logic [15:0]       mem_d, mem_q;
  logic              err;
  logic [1:0]        err_ch;

  mem_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk_24(clk_24), .reset(reset), .ch_cs(ch_cs), .ch_oe(ch_oe), .ch_we(ch_we),
    .ch_ad(ch_ad), .ch_d(ch_d), .ch_q(ch_q), .ch_busy(ch_busy), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds), .mem_we(mem_we), .mem_d(mem_d),
    .mem_q(mem_q), .err(err), .err_ch(err_ch)
  );

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [1:0]  ds;
    logic [15:0] d;
  } txn_t;

  txn_t exp_q[$];
  int   tog_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [15:0] rsp_data = 16'h0;
  int   ack_delay = 3;
  bit   ack_en = 1'b1;

  initial begin
    clk_24 = 1'b0;
    forever #21 clk_24 = ~clk_24;
  end

  initial forever begin
    @(posedge clk_24);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic we, input logic [1:0] ds, input logic [15:0] d);
    txn_t t;
    t.a = a; t.we = we; t.ds = ds; t.d = d;
    exp_q.push_back(t);
  endtask

  task automatic clear_in();
    ch_cs = '0; ch_oe = '0; ch_we = '0; ch_ad = '0; ch_d = '0;
  endtask

  task automatic set_ch(input int i, input logic cs, input logic oe, input logic we,
                        input logic [15:0] ad, input logic [7:0] d);
    ch_cs[i] = cs; ch_oe[i] = oe; ch_we[i] = we;
    ch_ad[i*AW +: AW] = ad;
    ch_d[i*DW +: DW] = d;
  endtask

  task automatic wait_idle(input int ch, input int maxc, input string name);
    int n;
    n = 0;
    @(negedge clk_24);
    while (ch_busy[ch] && n < maxc) begin
      @(negedge clk_24);
      n++;
    end
    chk({name, "_completed"}, 64'(ch_busy[ch]), 64'd0);
  endtask

  task automatic wait_req(input int maxc);
    int n;
    n = 0;
    @(negedge clk_24);
    while (mem_req == mem_ack && n < maxc) begin
      @(negedge clk_24);
      n++;
    end
    chk("req_issued", 64'(mem_req != mem_ack), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_24);
    reset = 1'b1;
    clear_in();
    repeat (2) @(negedge clk_24);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({p, "_mem_a"},   64'(mem_a),   64'd0);
    chk({p, "_mem_ds"},  64'(mem_ds),  64'd0);
    chk({p, "_mem_we"},  64'(mem_we),  64'd0);
    chk({p, "_mem_d"},   64'(mem_d),   64'd0);
    chk({p, "_ch_q"},    64'(ch_q),    64'd0);
    chk({p, "_ch_busy"}, 64'(ch_busy), 64'd0);
    chk({p, "_err"},     64'(err),     64'd0);
    chk({p, "_err_ch"},  64'(err_ch),  64'd0);
  endtask

  // SDRAM responder: toggles mem_ack ack_delay cycles after a new request
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_q = 16'h0;
    forever begin
      @(posedge clk_24);
      #1;
      if (reset) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req != mem_ack) begin
        wcnt++;
        if (ack_en && wcnt >= ack_delay) begin
          mem_q = rsp_data;
          mem_ack = mem_req;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // monitor: every mem_req toggle must match the next queued request, and the
  // request fields must not move without a toggle
  initial begin
    logic        prev_req;
    logic [34:0] held;
    txn_t        e;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(posedge clk_24);
      #1;
      if (reset) begin
        prev_req = mem_req;
        held = {mem_a, mem_we, mem_ds, mem_d};
      end else if (mem_req != prev_req) begin
        prev_req = mem_req;
        held = {mem_a, mem_we, mem_ds, mem_d};
        tog_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 64'(held), 64'h7_FFFF_FFFF_FF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_req", 64'(held), 64'({e.a, e.we, e.ds, e.d}));
        end
      end else begin
        chk("req_fields_stable", 64'({mem_a, mem_we, mem_ds, mem_d}), 64'(held));
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk_24);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int          n;
    logic        req_at;
    reset = 1'b1;
    clear_in();
    repeat (3) @(negedge clk_24);
    check_reset_vals("rst");
    reset = 1'b0;

    // ch0 read 0x1235, ack 3 cycles after issue
    @(negedge clk_24);
    set_ch(0, 1, 1, 0, 16'h1235, 8'h00);
    push(16'h1235, 1'b0, 2'b11, 16'h0000);
    rsp_data = 16'hA55A; ack_delay = 3; ack_en = 1'b1;
    @(negedge clk_24);
    chk("t1_req_before_issue", 64'(mem_req), 64'd0);
    chk("t1_busy_pending", 64'(ch_busy[0]), 64'd1);
    @(negedge clk_24);
    chk("t1_req_issue_edge", 64'(mem_req), 64'd1);
    repeat (2) @(negedge clk_24);
    chk("t1_busy_in_wait", 64'(ch_busy[0]), 64'd1);
    @(negedge clk_24);
    chk("t1_busy_after_ack", 64'(ch_busy[0]), 64'd0);
    chk("t1_ch_q0", 64'(ch_q[7:0]), 64'hA5);
    clear_in();

    // ch1 byte write, even address
    @(negedge clk_24);
    set_ch(1, 1, 0, 1, 16'h0100, 8'h3C);
    push(16'h0100, 1'b1, 2'b01, 16'h3C3C);
    wait_idle(1, 20, "t2");
    chk("t2_ch_q1_untouched", 64'(ch_q[15:8]), 64'h00);
    chk("t2_ch_q0_held", 64'(ch_q[7:0]), 64'hA5);
    clear_in();

    // simultaneous triggers after reset: ch0 first, ch1 the edge after ch0 completes
    do_reset();
    @(negedge clk_24);
    set_ch(0, 1, 1, 0, 16'h0200, 8'h00);
    set_ch(1, 1, 1, 0, 16'h0301, 8'h00);
    push(16'h0200, 1'b0, 2'b11, 16'h0000);
    push(16'h0301, 1'b0, 2'b11, 16'h0000);
    rsp_data = 16'hBEEF; ack_delay = 3;
    @(negedge clk_24);
    chk("t3_both_busy", 64'(ch_busy), 64'h3);
    wait_idle(1, 30, "t3");
    chk("t3_ch_q0", 64'(ch_q[7:0]), 64'hEF);
    chk("t3_ch_q1", 64'(ch_q[15:8]), 64'hBE);
    n = tog_q.size();
    chk("t3_issue_gap", (n >= 2) ? 64'(tog_q[n-1] - tog_q[n-2]) : 64'hFFFF, 64'd4);
    clear_in();

    // address change while the first read is in service
    @(negedge clk_24);
    set_ch(0, 1, 1, 0, 16'h0010, 8'h00);
    push(16'h0010, 1'b0, 2'b11, 16'h0000);
    push(16'h0011, 1'b0, 2'b11, 16'h0000);
    rsp_data = 16'h7E81; ack_delay = 5;
    wait_req(10);
    ch_ad[15:0] = 16'h0011;
    wait_idle(0, 60, "t4");
    chk("t4_ch_q0", 64'(ch_q[7:0]), 64'h7E);
    clear_in();

    // oe and we rise together: write wins, odd address
    @(negedge clk_24);
    set_ch(0, 1, 1, 1, 16'h0021, 8'h5A);
    push(16'h0021, 1'b1, 2'b10, 16'h5A5A);
    ack_delay = 2;
    wait_idle(0, 20, "t5");
    chk("t5_ch_q0_held", 64'(ch_q[7:0]), 64'h7E);
    clear_in();

    // ack never returns: abort TMO cycles into WAIT
    ack_en = 1'b0;
    @(negedge clk_24);
    set_ch(1, 1, 1, 0, 16'h0400, 8'h00);
    push(16'h0400, 1'b0, 2'b11, 16'h0000);
    wait_req(10);
    req_at = mem_req;
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk_24);
      chk("t6_err_early", 64'(err), 64'd0);
    end
    @(negedge clk_24);
    chk("t6_err_pulse", 64'(err), 64'd1);
    chk("t6_err_ch", 64'(err_ch), 64'd1);
    chk("t6_busy_cleared", 64'(ch_busy), 64'd0);
    chk("t6_req_unchanged", 64'(mem_req), 64'(req_at));
    @(negedge clk_24);
    chk("t6_err_one_cycle", 64'(err), 64'd0);
    chk("t6_ch_q1_held", 64'(ch_q[15:8]), 64'hBE);
    clear_in();

    // reset in the middle of WAIT
    do_reset();
    @(negedge clk_24);
    check_reset_vals("t7_pre");
    set_ch(0, 1, 1, 0, 16'h0500, 8'h00);
    push(16'h0500, 1'b0, 2'b11, 16'h0000);
    wait_req(10);
    repeat (2) @(negedge clk_24);
    reset = 1'b1;
    clear_in();
    @(negedge clk_24);
    check_reset_vals("t7_mid_wait");
    reset = 1'b0;
    repeat (5) @(negedge clk_24);
    chk("t7_no_residual_busy", 64'(ch_busy), 64'd0);
    chk("t7_no_residual_req", 64'(mem_req), 64'd0);

    // normal operation resumes after reset
    ack_en = 1'b1; ack_delay = 2; rsp_data = 16'h1357;
    @(negedge clk_24);
    set_ch(1, 1, 1, 0, 16'h0601, 8'h00);
    push(16'h0601, 1'b0, 2'b11, 16'h0000);
    wait_idle(1, 20, "t8");
    chk("t8_ch_q1", 64'(ch_q[15:8]), 64'h13);
    clear_in();

    repeat (3) @(negedge clk_24);
    chk("sb_all_requests_seen", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
